conditional_select: RTL and testbench

CONDITIONAL_SELECT -- requirements
Module: conditional_select

---
 rtl/conditional_select.sv | 171 +++++++++++++++++
 tb/tb_conditional_select.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conditional_select.sv
// -----------------------------------------------------------------------------
// conditional_select
//
// Per-cycle data selector with a start delay and a registered output pipeline.
// A run pulse arms the block. It then waits delay0 running cycles, and then
// LATENCY more running cycles while the pipeline fills. After that, out_valid
// is high on every running cycle. The pipeline keeps shifting during the delay.
// Those early outputs are simply flagged invalid.
//
// Parameters
//   DATA_W   width of each data word
//   N_IN     number of data inputs (2..16)
//   LATENCY  output pipeline depth in cycles (1..4)
//   DELAY_W  width of the start-delay counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   running    advance enable; 0 freezes all state
//   run        single-cycle start pulse (loads delay, clears fill and hold)
//   mode       0 SELECT, 1 MIN, 2 MAX, 3 HOLD
//   delay0     cycles to wait after run before results count as valid
//   sel        selector for SELECT (low bits) and HOLD (bit 0)
//   in_data    packed inputs, in[k] = in_data[k*DATA_W +: DATA_W]
//   out0       result, LATENCY running cycles after its inputs were sampled
//   out_valid  out0 was computed from post-delay inputs
// -----------------------------------------------------------------------------
module conditional_select #(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 4,
    parameter int LATENCY = 1,
    parameter int DELAY_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     running,
    input  logic                     run,
    input  logic [1:0]               mode,
    input  logic [DELAY_W-1:0]       delay0,
    input  logic [31:0]              sel,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [DATA_W-1:0]        out0,
    output logic                     out_valid
);

    localparam int IDX_W  = $clog2(N_IN);
    localparam int FILL_W = $clog2(LATENCY + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LATENCY);

    typedef enum logic [1:0] {
        MODE_SELECT = 2'd0,
        MODE_MIN    = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    // IDLE until the first run pulse, so that a free-running enable after
    // reset cannot fill the pipeline and raise out_valid on its own.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   pipe_q [LATENCY];
    logic [DATA_W-1:0]   in_w   [N_IN];
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   sel_word;
    logic [IDX_W-1:0]    idx;

    // Upper selector bits are only meaningful to other users of sel.
    logic unused_sel;
    assign unused_sel = ^sel[31:IDX_W];

    assign idx = sel[IDX_W-1:0];

    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            in_w[k] = in_data[k*DATA_W +: DATA_W];
        end
    end

    // An index that is not a power of two can point past the last input.
    // The loop leaves sel_word at zero in that case.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_word = in_w[k];
            end
        end
    end

    // HOLD reports the hold register's next value. A run pulse clears it
    // even in the same cycle.
    always_comb begin
        hold_d = hold_q;
        if (run) begin
            hold_d = '0;
        end else if (running && mode_e'(mode) == MODE_HOLD && sel[0]) begin
            hold_d = in_w[0];
        end
    end

    // Ties go to in[0], so in[1] wins only on a strict compare.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        result = '0;
        case (mode_e'(mode))
            MODE_SELECT: result = sel_word;
            MODE_MIN:    result = ($signed(in_w[1]) < $signed(in_w[0])) ? in_w[1] : in_w[0];
            MODE_MAX:    result = ($signed(in_w[1]) > $signed(in_w[0])) ? in_w[1] : in_w[0];
            MODE_HOLD:   result = hold_d;
            default:     result = '0;
        endcase
    end

    // Next-state logic for the delay/fill sequencing. run takes priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        if (run) begin
            state_d = ST_ACTIVE;
            cnt_d   = delay0;
            fill_d  = '0;
        end else if (running && state_q == ST_ACTIVE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

    // NOTE: the pipeline array is reset, because out0 must read zero while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (running) begin
            pipe_q[0] <= result;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign out0      = pipe_q[LATENCY-1];
    assign out_valid = running && (state_q == ST_ACTIVE) && (cnt_q == '0) && (fill_q == FILL_FULL);

endmodule

// File: tb/tb_conditional_select.sv
// -----------------------------------------------------------------------------
// tb_conditional_select
//
// Two instances share one stimulus stream:
//   dut_a: N_IN=4, LATENCY=2
//   dut_b: N_IN=3, LATENCY=1
// The reference model does not track a delay counter or a fill counter.
// After a run it counts the running cycles, and a result is valid once that
// count reaches delay0 + LATENCY. The data path is a plain history of results,
// and out0 is the entry from LATENCY running cycles ago.
// -----------------------------------------------------------------------------
module tb_conditional_select;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          running = 1'b0;
    logic          run = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [31:0]   delay0 = '0;
    logic [31:0]   sel = '0;
    logic [127:0]  in_bus = '0;
    logic [95:0]   in_b;
    logic [31:0]   oa, ob;
    logic          va, vb;

    int checks   = 0;
    int failures = 0;

    assign in_b = in_bus[95:0];

    always #5 clk = ~clk;

    conditional_select #(.DATA_W(32), .N_IN(4), .LATENCY(2), .DELAY_W(32)) dut_a (
        .clk(clk), .rst(rst), .running(running), .run(run), .mode(mode),
        .delay0(delay0), .sel(sel), .in_data(in_bus), .out0(oa), .out_valid(va)
    );

    conditional_select #(.DATA_W(32), .N_IN(3), .LATENCY(1), .DELAY_W(32)) dut_b (
        .clk(clk), .rst(rst), .running(running), .run(run), .mode(mode),
        .delay0(delay0), .sel(sel), .in_data(in_b), .out0(ob), .out_valid(vb)
    );

    // ---------------- reference model ----------------
    int          lat_m [2] = '{2, 1};
    int          nin_m [2] = '{4, 3};
    logic [31:0] hist_m [2][4];
    logic [31:0] hold_m [2];
    bit          active_m [2];
    int          k_m [2];
    int          dly_m [2];

    function automatic logic [31:0] word(input int k);
        return in_bus[k*32 +: 32];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) hist_m[m][i] = '0;
            hold_m[m]   = '0;
            active_m[m] = 1'b0;
            k_m[m]      = 0;
            dly_m[m]    = 0;
        end
    endtask

    task automatic model_step(input int m);
        logic [31:0] res;
        logic [31:0] nh;
        int          idx;
        nh = hold_m[m];
        if (run) nh = '0;
        else if (running && mode == 2'd3 && sel[0]) nh = word(0);
        case (mode)
            // Both instances index with the low clog2(N_IN) = 2 selector bits.
            2'd0: begin
                idx = int'(sel[1:0]);
                res = (idx < nin_m[m]) ? word(idx) : 32'd0;
            end
            2'd1:    res = ($signed(word(1)) < $signed(word(0))) ? word(1) : word(0);
            2'd2:    res = ($signed(word(1)) > $signed(word(0))) ? word(1) : word(0);
            default: res = nh;
        endcase
        hold_m[m] = nh;
        if (running) begin
            for (int i = 3; i > 0; i--) hist_m[m][i] = hist_m[m][i-1];
            hist_m[m][0] = res;
        end
        if (run) begin
            active_m[m] = 1'b1;
            k_m[m]      = 0;
            dly_m[m]    = int'(delay0);
        end else if (running && active_m[m] && k_m[m] < 100000) begin
            k_m[m]++;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic exp_v;
        for (int m = 0; m < 2; m++) begin
            exp_v = running && active_m[m] && (k_m[m] >= dly_m[m] + lat_m[m]);
            chk($sformatf("%s/%s/out0", tag, m == 0 ? "a" : "b"),
                m == 0 ? oa : ob, hist_m[m][lat_m[m]-1]);
            chk($sformatf("%s/%s/valid", tag, m == 0 ? "a" : "b"),
                {31'd0, m == 0 ? va : vb}, {31'd0, exp_v});
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        @(negedge clk);
        cmp_model(tag);
    endtask

    task automatic set_in(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
        in_bus = {w3, w2, w1, w0};
    endtask

    initial begin
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_out0_a", oa, 32'd0);
        chk("reset_valid_a", {31'd0, va}, 32'd0);
        chk("reset_out0_b", ob, 32'd0);
        rst = 1'b1;

        // Idle after reset: running without a run pulse never validates.
        running = 1'b1;
        repeat (4) cyc("idle");
        chk("idle_valid_a", {31'd0, va}, 32'd0);
        chk("idle_valid_b", {31'd0, vb}, 32'd0);

        // SELECT timing: LATENCY=2, delay0=0, sel=2.
        set_in(32'd10, 32'd20, 32'd30, 32'd40);
        mode = 2'd0; sel = 32'd2; delay0 = 32'd0;
        run = 1'b1; cyc("sel_run");
        run = 1'b0; cyc("sel_c1");
        chk("sel_c1_valid_a", {31'd0, va}, 32'd0);
        cyc("sel_c2");
        chk("sel_c2_out0_a", oa, 32'd30);
        chk("sel_c2_valid_a", {31'd0, va}, 32'd1);

        // SELECT out of range on the 3-input instance.
        sel = 32'd3; cyc("oor_c1");
        chk("oor_out0_b", ob, 32'd0);
        cyc("oor_c2");
        chk("oor_out0_a", oa, 32'd40);

        // MIN/MAX, signed, with ties.
        set_in(32'hFFFF_FFFB, 32'd7, 32'd0, 32'd0);
        mode = 2'd1; cyc("min1"); cyc("min2");
        chk("min_neg_a", oa, 32'hFFFF_FFFB);
        mode = 2'd2; cyc("max1"); cyc("max2");
        chk("max_pos_a", oa, 32'd7);
        set_in(32'd9, 32'd9, 32'd0, 32'd0);
        mode = 2'd1; cyc("tmin1"); cyc("tmin2");
        chk("min_tie_a", oa, 32'd9);
        mode = 2'd2; cyc("tmax1"); cyc("tmax2");
        chk("max_tie_a", oa, 32'd9);

        // Delay on the LATENCY=1 instance, first without stalls.
        delay0 = 32'd3; run = 1'b1; cyc("dly_run");
        run = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc("dly");
            chk($sformatf("dly_c%0d_valid_b", i), {31'd0, vb}, 32'd0);
        end
        cyc("dly_c4");
        chk("dly_c4_valid_b", {31'd0, vb}, 32'd1);

        // The same delay with two stalled cycles in the middle.
        run = 1'b1; cyc("stl_run");
        run = 1'b0; cyc("stl_c1"); cyc("stl_c2");
        running = 1'b0; cyc("stl_c3"); cyc("stl_c4");
        running = 1'b1; cyc("stl_c5");
        chk("stl_c5_valid_b", {31'd0, vb}, 32'd0);
        cyc("stl_c6");
        chk("stl_c6_valid_b", {31'd0, vb}, 32'd1);

        // HOLD: load 0x55, then keep it while in0 changes to 0xAA.
        mode = 2'd3; sel = 32'd1; set_in(32'h55, 32'd0, 32'd0, 32'd0);
        cyc("hold_ld");
        sel = 32'd0; set_in(32'hAA, 32'd0, 32'd0, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc("hold_keep");
            chk($sformatf("hold_keep%0d_a", i), oa, 32'h55);
        end
        run = 1'b1; cyc("hold_run");
        run = 1'b0; cyc("hold_clr1");
        chk("hold_clr1_a", oa, 32'd0);
        cyc("hold_clr2");
        chk("hold_clr2_a", oa, 32'd0);

        // Reset asserted mid-fill acts at once; no run follows it.
        mode = 2'd0; sel = 32'd1; delay0 = 32'd0; set_in(32'd1, 32'd2, 32'd3, 32'd4);
        run = 1'b1; cyc("rst_run");
        run = 1'b0; cyc("rst_fill");
        #2 rst = 1'b0;
        #1;
        chk("rst_async_out0_a", oa, 32'd0);
        chk("rst_async_valid_a", {31'd0, va}, 32'd0);
        chk("rst_async_out0_b", ob, 32'd0);
        chk("rst_async_valid_b", {31'd0, vb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) cyc("rst_after");
        chk("rst_after_valid_a", {31'd0, va}, 32'd0);
        chk("rst_after_valid_b", {31'd0, vb}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w0;
            w0      = $urandom;
            run     = ($urandom_range(0, 15) == 0);
            running = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom_range(0, 3));
            sel     = $urandom;
            delay0  = 32'($urandom_range(0, 4));
            set_in(w0, ($urandom_range(0, 3) == 0) ? w0 : $urandom, $urandom, $urandom);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
